// File: rtl/pe_route_dispatcher_pkg.sv
// Shared definitions for the PE route dispatcher: destination encodings and a
// pointer helper used by the output queues.
package pe_route_dispatcher_pkg;

    localparam logic DEST_OUT0 = 1'b0;
    localparam logic DEST_OUT1 = 1'b1;

    // Pointers carry one wrap bit above the index; full means same index, other lap.
    function automatic logic ptr_full(input logic wrap_w, input logic wrap_r, input logic idx_eq);
        return (wrap_w != wrap_r) && idx_eq;
    endfunction

endpackage

// File: rtl/pe_route_fifo.sv
// First-word-fall-through queue for one dispatcher output; head is valid
// whenever the queue is not empty.
module pe_route_fifo
    import pe_route_dispatcher_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              w_push;
    logic              w_pop;

    assign empty  = (r_wptr == r_rptr);
    assign full   = ptr_full(r_wptr[AW], r_rptr[AW], r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign head   = r_mem[r_rptr[AW-1:0]];
    // Guard internally so a misbehaving caller cannot corrupt the pointers.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pe_route_dispatcher.sv
// Routes one input stream to two independent FWFT output queues, either by
// explicit destination or round-robin, and counts words accepted per output.
module pe_route_dispatcher
    import pe_route_dispatcher_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dest,
    input  logic              rr_mode,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);
    logic             r_rr_ptr;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;
    logic             w_sel;
    logic             w_xfer;
    logic             w_push0;
    logic             w_push1;
    logic             w_full0;
    logic             w_full1;
    logic             w_empty0;
    logic             w_empty1;

    // in_ready looks only at registered fullness, so a same-cycle pop never frees a slot.
    assign w_sel    = rr_mode ? r_rr_ptr : in_dest;
    assign in_ready = (w_sel == DEST_OUT1) ? ~w_full1 : ~w_full0;
    assign w_xfer   = in_valid & in_ready;
    assign w_push0  = w_xfer & (w_sel == DEST_OUT0);
    assign w_push1  = w_xfer & (w_sel == DEST_OUT1);

    assign out0_valid = ~w_empty0;
    assign out1_valid = ~w_empty1;
    assign cnt0       = r_cnt0;
    assign cnt1       = r_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
            r_cnt0   <= '0;
            r_cnt1   <= '0;
        end else begin
            if (w_xfer && rr_mode) r_rr_ptr <= ~r_rr_ptr;
            if (w_push0)           r_cnt0   <= r_cnt0 + CNT_W'(1);
            if (w_push1)           r_cnt1   <= r_cnt1 + CNT_W'(1);
        end
    end

    pe_route_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_q0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push0),
        .push_data (in_data),
        .pop       (out0_ready),
        .full      (w_full0),
        .empty     (w_empty0),
        .head      (out0_data)
    );

    pe_route_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_q1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push1),
        .push_data (in_data),
        .pop       (out1_ready),
        .full      (w_full1),
        .empty     (w_empty1),
        .head      (out1_data)
    );

endmodule
